stage_fetch_q: RTL and testbench
================================

STAGE_FETCH_Q -- requirements
Module: stage_fetch_q

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000: address of the first fetch after reset.
REQ-002 SHALL have parameter DEPTH, default 4: fetch-queue entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fe_enable  input  1  fetch permitted this cycle.
REQ-006 SHALL have port pc_wen  input  1  redirect request (branch or trap).
REQ-007 SHALL have port pc_in  input  32  redirect target.
REQ-008 SHALL have port fe_req  output  1  memory fetch request.
REQ-009 SHALL have port fe_addr  output  32  fetch address.
REQ-010 SHALL have port fe_ack  input  1  fetch accepted; fe_data valid in the same cycle.
REQ-011 SHALL have port fe_data  input  32  fetched instruction word.
REQ-012 SHALL have port de_stall  input  1  decode is not accepting this cycle.
REQ-013 SHALL have port de_valid  output  1  queue head valid.
REQ-014 SHALL have port de_insn  output  32  queue head instruction.
REQ-015 SHALL have port de_pc  output  32  queue head PC.
REQ-016 SHALL have port fq_count  output  $clog2(DEPTH)+1  occupancy, for performance counters.

Function
REQ-017 SHALL hold a 32-bit fetch PC register, pc, and a DEPTH-entry FIFO whose entries are {pc, insn}.
REQ-018 SHALL drive fe_addr = pc_wen ? pc_in : pc, combinationally.
REQ-019 SHALL drive fe_req = fe_enable & (pc_wen | (fq_count != DEPTH)); a redirect treats the queue as empty.
REQ-020 SHALL push {fe_addr, fe_data} on fe_req & fe_ack, and set pc <= fe_addr + 4 (mod 2^32, wrapping).
REQ-021 SHALL leave pc unchanged when there is no push and no redirect.
REQ-022 SHALL, when pc_wen=1 without an ack, set pc <= pc_in.
REQ-023 SHALL drive de_valid = (fq_count != 0); de_insn and de_pc come from the head entry with zero combinational dependence on fe_data.
REQ-024 SHALL pop when de_valid & ~de_stall & ~pc_wen.
REQ-025 SHALL keep the head entry stable while de_stall=1.
REQ-026 SHALL, on pc_wen, discard every queued entry in that cycle; the next-cycle queue holds only the redirect-target entry if it was acked, otherwise it is empty.
REQ-027 SHALL, on a simultaneous push and pop, leave fq_count unchanged and keep FIFO order.
REQ-028 SHALL never push when full without a redirect (guaranteed by REQ-019); a pop from a full queue re-enables fe_req in the following cycle.
REQ-029 SHALL wrap the read and write pointers modulo DEPTH.
REQ-030 SHALL hold de_valid=0 with no pop side effects when empty, even if de_stall=0.
REQ-031 SHALL deliver latency ack→de_valid of one cycle when the queue was empty.

Reset
REQ-032 SHALL, while reset_n=0, immediately and asynchronously set pc=RESET_PC, pointers=0, fq_count=0 and de_valid=0.
REQ-033 SHALL leave queue data storage unreset; de_insn and de_pc are don't-care while de_valid=0.
REQ-034 SHALL drive fe_addr=RESET_PC in the first cycle after reset_n rises, when pc_wen=0.
REQ-035 SHALL, on reset asserted mid-operation, lose all queued entries and never present them afterwards.

Structure
REQ-036 SHALL take XLEN=32 and the default reset vector 32'h80000000 from the shared package riscv_pkg.
REQ-037 SHALL implement the queue as sub-module fetch_fifo: parameterised width and depth, synchronous flush, push/pop/count.
REQ-038 SHALL keep the PC register and the request logic in stage_fetch_q.

Verification
REQ-039 SHALL cover: reset, fe_enable=1, fe_ack always 1, de_stall=0 → fe_addr sequence 80000000, 80000004, 80000008; de_pc follows one cycle later.
REQ-040 SHALL cover: DEPTH=4, de_stall=1, fe_ack=1 → 4 pushes, then fe_req=0, fq_count=4, de_pc=80000000 held; release → fe_req=1 the next cycle.
REQ-041 SHALL cover: 3 entries queued, pc_wen=1, pc_in=80000100, fe_ack=1 → next cycle fq_count=1, de_pc=80000100, then fe_addr=80000104.
REQ-042 SHALL cover: pc_wen=1, pc_in=80000200, fe_ack=0 → next cycle fq_count=0, de_valid=0, fe_addr=80000200.
REQ-043 SHALL cover: pc_in=FFFFFFFC, acked → next fe_addr=00000000.
REQ-044 SHALL cover: reset_n pulled low mid-burst between clock edges → fq_count=0 and de_valid=0 before the next edge; after release fe_addr=80000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, reset vector and the
// fetch-queue entry layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue storage: DEPTH-entry FIFO with synchronous flush that may
// accept a fresh entry in the same cycle as the flush.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    wr_idx;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & (flush | ~full);
  assign do_pop  = pop & ~empty & ~flush;
  // A push during flush lands in slot 0 so the queue restarts from pointer 0.
  assign wr_idx  = flush ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? AW'(1) : '0;
      cnt    <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/stage_fetch_q.sv
// Instruction fetch stage: fetch PC, request generation and a decoupling
// queue of {pc, insn} entries feeding decode.
module stage_fetch_q
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fe_enable,
  input  logic                   pc_wen,
  input  logic [31:0]            pc_in,
  output logic                   fe_req,
  output logic [31:0]            fe_addr,
  input  logic                   fe_ack,
  input  logic [31:0]            fe_data,
  input  logic                   de_stall,
  output logic                   de_valid,
  output logic [31:0]            de_insn,
  output logic [31:0]            de_pc,
  output logic [$clog2(DEPTH):0] fq_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic            push;
  logic            pop;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign fe_addr  = pc_wen ? pc_in : pc;
  // A redirect flushes the queue, so a full queue must not block its fetch.
  assign fe_req   = fe_enable & (pc_wen | (fq_count != CW'(DEPTH)));
  assign push     = fe_req & fe_ack;
  assign de_valid = (fq_count != '0);
  assign pop      = de_valid & ~de_stall & ~pc_wen;

  assign wr_entry.pc   = fe_addr;
  assign wr_entry.insn = fe_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    pc <= RESET_PC;
    else if (push)   pc <= seq_pc(fe_addr);
    else if (pc_wen) pc <= pc_in;
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (pc_wen),
    .push    (push),
    .wdata   (wr_entry),
    .pop     (pop),
    .rdata   (head),
    .count   (fq_count)
  );

  assign de_pc   = head.pc;
  assign de_insn = head.insn;

endmodule

// File: tb/tb_stage_fetch_q.sv
// Bench for stage_fetch_q: directed vector table, mid-burst reset sequence
// and randomized traffic against a queue-based reference model.
module tb_stage_fetch_q;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        fe_enable;
  logic        pc_wen;
  logic [31:0] pc_in;
  logic        fe_req;
  logic [31:0] fe_addr;
  logic        fe_ack;
  logic [31:0] fe_data;
  logic        de_stall;
  logic        de_valid;
  logic [31:0] de_insn;
  logic [31:0] de_pc;
  logic [2:0]  fq_count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  stage_fetch_q #(
    .RESET_PC (32'h8000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fe_enable (fe_enable),
    .pc_wen    (pc_wen),
    .pc_in     (pc_in),
    .fe_req    (fe_req),
    .fe_addr   (fe_addr),
    .fe_ack    (fe_ack),
    .fe_data   (fe_data),
    .de_stall  (de_stall),
    .de_valid  (de_valid),
    .de_insn   (de_insn),
    .de_pc     (de_pc),
    .fq_count  (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        wen;
    logic [31:0] pin;
    logic        ack;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic [2:0]  e_cnt;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    fe_enable = 1'b0;
    pc_wen    = 1'b0;
    pc_in     = '0;
    fe_ack    = 1'b0;
    fe_data   = '0;
    de_stall  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic rst, en, wen, input logic [31:0] pin,
                              input logic ack, stall, e_req, input logic [31:0] e_addr,
                              input logic [2:0] e_cnt, input logic e_valid,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.en = en; v.wen = wen; v.pin = pin; v.ack = ack; v.stall = stall;
    v.e_req = e_req; v.e_addr = e_addr; v.e_cnt = e_cnt; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  // Instruction words are the complement of their fetch address, so the
  // expected head word follows directly from the expected head PC.
  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    if (v.rst) do_reset();
    @(negedge clk);
    fe_enable = v.en;
    pc_wen    = v.wen;
    pc_in     = v.pin;
    fe_ack    = v.ack;
    de_stall  = v.stall;
    fe_data   = ~v.e_addr;
    #1;
    tag = $sformatf("vec%0d", idx);
    chk({tag, ".fe_req"},   {31'd0, fe_req},   {31'd0, v.e_req});
    chk({tag, ".fe_addr"},  fe_addr,           v.e_addr);
    chk({tag, ".fq_count"}, {29'd0, fq_count}, {29'd0, v.e_cnt});
    chk({tag, ".de_valid"}, {31'd0, de_valid}, {31'd0, v.e_valid});
    if (v.e_valid) begin
      chk({tag, ".de_pc"},   de_pc,   v.e_pc);
      chk({tag, ".de_insn"}, de_insn, ~v.e_pc);
    end
  endtask

  logic [63:0] mq[$];
  logic [31:0] mpc;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    #12;
    reset_n = 1'b1;

    // rst en wen pc_in ack stall | req addr cnt valid de_pc
    // sequential fetch, free-flowing decode
    tbl.push_back(mk(1,1,0,32'h0,1,0, 1,32'h8000_0000,0,0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,1,0, 1,32'h8000_0004,1,1,32'h8000_0000));
    tbl.push_back(mk(0,1,0,32'h0,1,0, 1,32'h8000_0008,1,1,32'h8000_0004));
    // fill to full under stall, then release
    tbl.push_back(mk(1,1,0,32'h0,1,1, 1,32'h8000_0000,0,0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,1,1, 1,32'h8000_0004,1,1,32'h8000_0000));
    tbl.push_back(mk(0,1,0,32'h0,1,1, 1,32'h8000_0008,2,1,32'h8000_0000));
    tbl.push_back(mk(0,1,0,32'h0,1,1, 1,32'h8000_000C,3,1,32'h8000_0000));
    tbl.push_back(mk(0,1,0,32'h0,1,1, 0,32'h8000_0010,4,1,32'h8000_0000));
    tbl.push_back(mk(0,1,0,32'h0,1,0, 0,32'h8000_0010,4,1,32'h8000_0000));
    tbl.push_back(mk(0,1,0,32'h0,1,1, 1,32'h8000_0010,3,1,32'h8000_0004));
    // three queued, acked redirect
    tbl.push_back(mk(1,1,0,32'h0,1,1, 1,32'h8000_0000,0,0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,1,1, 1,32'h8000_0004,1,1,32'h8000_0000));
    tbl.push_back(mk(0,1,0,32'h0,1,1, 1,32'h8000_0008,2,1,32'h8000_0000));
    tbl.push_back(mk(0,1,1,32'h8000_0100,1,0, 1,32'h8000_0100,3,1,32'h8000_0000));
    tbl.push_back(mk(0,1,0,32'h0,0,1, 1,32'h8000_0104,1,1,32'h8000_0100));
    // unacked redirect
    tbl.push_back(mk(0,1,1,32'h8000_0200,0,1, 1,32'h8000_0200,1,1,32'h8000_0100));
    tbl.push_back(mk(0,1,0,32'h0,0,1, 1,32'h8000_0200,0,0,32'h0));
    // address wrap and fetch disabled
    tbl.push_back(mk(0,1,1,32'hFFFF_FFFC,1,1, 1,32'hFFFF_FFFC,0,0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,0,1, 1,32'h0000_0000,1,1,32'hFFFF_FFFC));
    tbl.push_back(mk(0,0,0,32'h0,1,1, 0,32'h0000_0000,1,1,32'hFFFF_FFFC));

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // Reset pulled mid-burst between edges
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fe_enable = 1'b1; fe_ack = 1'b1; de_stall = 1'b1; fe_data = 32'h1234_5678;
    end
    @(posedge clk);
    #2;
    chk("burst.cnt_before", {29'd0, fq_count}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("rst.fq_count", {29'd0, fq_count}, 32'd0);
    chk("rst.de_valid", {31'd0, de_valid}, 32'd0);
    chk("rst.fe_addr",  fe_addr, 32'h8000_0000);
    @(negedge clk);
    fe_ack = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rel.fe_addr",  fe_addr, 32'h8000_0000);
    @(negedge clk);
    #1;
    chk("rel.de_valid", {31'd0, de_valid}, 32'd0);
    chk("rel.fe_addr2", fe_addr, 32'h8000_0000);

    // Randomized traffic against the reference queue
    do_reset();
    mq.delete();
    mpc = 32'h8000_0000;
    for (int c = 0; c < 400; c++) begin
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      @(negedge clk);
      fe_enable = ($urandom_range(7) != 0);
      pc_wen    = ($urandom_range(9) == 0);
      pc_in     = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      fe_ack    = ($urandom_range(3) != 0);
      de_stall  = ($urandom_range(2) == 0);
      fe_data   = $urandom();
      e_req   = fe_enable && (pc_wen || mq.size() != DEPTH);
      e_addr  = pc_wen ? pc_in : mpc;
      e_valid = (mq.size() != 0);
      #1;
      chk("rnd.fe_req",   {31'd0, fe_req},   {31'd0, e_req});
      chk("rnd.fe_addr",  fe_addr,           e_addr);
      chk("rnd.fq_count", {29'd0, fq_count}, mq.size());
      chk("rnd.de_valid", {31'd0, de_valid}, {31'd0, e_valid});
      if (e_valid) begin
        chk("rnd.de_pc",   de_pc,   mq[0][63:32]);
        chk("rnd.de_insn", de_insn, mq[0][31:0]);
      end
      @(posedge clk);
      if (pc_wen) mq.delete();
      else if (e_valid && !de_stall) void'(mq.pop_front());
      if (e_req && fe_ack) begin
        mq.push_back({e_addr, fe_data});
        mpc = e_addr + 32'd4;
      end else if (pc_wen) begin
        mpc = pc_in;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
